// File: rtl/modm_mult_seq.sv
// ============================================================================
//  Module      : modm_mult_seq
//  Description : Sequential shift-and-add multiplier modulo M = 2^N - 1,
//                one multiplier bit per cycle, valid/ready on both sides.
//                Optional build macro MODM_NORMALIZE_EN maps a result of M to 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module modm_mult_seq #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] z,
    output logic         busy
);

    localparam int                 c_cnt_w = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);
    localparam logic [N-1:0]       c_m     = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_acc;
    logic [N-1:0]       r_mcand;
    logic [N-1:0]       r_mplier;
    logic [c_cnt_w-1:0] r_cnt;
    logic [N-1:0]       r_z;
    logic [N:0]         w_sum;
    logic [N-1:0]       w_eac;
    logic [N-1:0]       w_acc_nxt;
    logic [N-1:0]       w_z_fin;

    // End-around carry: the carry out of bit N-1 has weight 2^N == 1 (mod M).
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_mcand};
    assign w_eac     = w_sum[N-1:0] + {{(N-1){1'b0}}, w_sum[N]};
    assign w_acc_nxt = r_mplier[0] ? w_eac : r_acc;

`ifdef MODM_NORMALIZE_EN
    assign w_z_fin = (w_acc_nxt == c_m) ? '0 : w_acc_nxt;
`else
    assign w_z_fin = w_acc_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)          w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == c_last)   w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)         w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_z      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc    <= '0;
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    // Rotate-left by one is doubling modulo 2^N - 1.
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= {r_mcand[N-2:0], r_mcand[N-1]};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_last) begin
                        r_z <= w_z_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure state decodes; rst gates in_ready directly.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign z         = r_z;

endmodule

`default_nettype wire

// File: doc/modm_mult_seq.md
# modm_mult_seq

Sequential, parameterised multiplier modulo the Mersenne modulus M = 2^N − 1. It computes (a × b) mod M with a shift-and-add datapath that processes one multiplier bit per cycle. It uses end-around-carry addition and rotate-left doubling, so no divider is needed. It sits in the residue-arithmetic datapath as the width-generic, flow-controlled successor to the fixed 3-bit combinational mod-7 multiplier.

## Interface
- N, default 3: operand/result width; legal range 2..16; modulus M = 2^N − 1.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand pair on a, b is valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  N  multiplicand; value M (all ones) is a legal alias of 0.
- b  input  N  multiplier; value M is a legal alias of 0.
- out_valid  output  1  result on z is valid.
- out_ready  input  1  consumer accepts z.
- z  output  N  product residue.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid: load acc = 0, mcand = a, mplier = b, cnt = 0, then go to RUN.
- RUN (exactly N cycles; in_ready = 0):
  - If mplier[0] = 1, set acc = eac(acc, mcand).
  - mcand = rotl(mcand, 1). This is the mod-M doubling.
  - mplier = mplier >> 1.
  - cnt = cnt + 1.
  - On the step where cnt = N−1, write the final acc into z, set out_valid and go to DONE.
- eac(x, y):
  - s = x + y, computed at N+1 bits.
  - result = s[N−1:0] + s[N].
  - The second addition cannot overflow, because x, y ≤ M.
- DONE:
  - z and out_valid are held stable.
  - On out_valid & out_ready: out_valid drops and the block returns to IDLE.
  - in_ready stays 0 in DONE.
- Operands are captured only at acceptance. Changes on a and b after that are ignored.
- in_valid while not in IDLE is ignored. The upstream producer must hold in_valid until it sees in_ready.
- Reset mid-operation: any in-flight product is discarded; the next cycle is IDLE with all outputs at reset values.
- Reset values:
  - in_ready = 0 while rst is high, 1 in the first cycle after.
  - out_valid = 0.
  - z = 0.
  - busy = 0.

## Timing
- Acceptance handshake at edge t (in_valid & in_ready).
- RUN occupies edges t+1 .. t+N.
- out_valid is high from the cycle after edge t+N. Latency from acceptance to result is N+1 cycles.
- Minimum initiation interval is N+2 cycles with out_ready held high: accept, N RUN cycles, one DONE handshake, then IDLE.
- out_ready has no combinational path to in_ready. All outputs are registered or decoded directly from the state.

## Configuration
- MODM_NORMALIZE_EN
  - Defined: if the final acc equals M (all ones), z is forced to 0. z is always in 0..M−1.
  - Undefined: z is the raw final acc. It may equal M, meaning residue 0 (for example, a = M, b = 1 gives z = M).
  - Latency, handshake and state machine are identical in both builds. Normalisation is folded into the final RUN step.

## Test plan
- N=3, a=3, b=5 -> z=1 exactly 4 cycles after acceptance. busy is high in those cycles; in_ready is low until the out handshake.
- N=3, a=7, b=1 -> z=0 with MODM_NORMALIZE_EN defined; z=7 without it. a=0, b=7 -> z=0 in both builds.
- N=3, all 64 (a, b) pairs back-to-back with out_ready=1, normalised build:
  - every z equals (a·b) mod 7;
  - a new acceptance happens every 5 cycles.
- N=8, a=200, b=100 -> z=110 after 9 cycles. a=255, b=37 -> z=0 in the normalised build.
- Backpressure: result ready with out_ready held low for 6 cycles.
  - z and out_valid stay stable; in_ready=0.
  - A new in_valid pulse in that window is not accepted.
  - When out_ready rises: one handshake, then IDLE.
- rst asserted for 1 cycle during the 2nd RUN cycle:
  - next cycle is IDLE with out_valid=0, z=0, busy=0;
  - no result for the aborted operation ever appears;
  - a fresh operand pair then completes correctly.
